md5_mem_responder: RTL and testbench

Dual-channel memory responder that terminates the two-lane HLS memory interface (`Mout_*` / `M_*`) driven by the `md5` core. It replaces the hard-wired stub responses in the board top with a real word-addressed RAM window. The RAM supports byte, halfword and word accesses on each lane and returns a one-cycle `M_DataRdy` handshake. A host-side port lets the top preload the message and read back the digest.

---
 rtl/md5_mem_responder.sv | 112 +++++++++++
 tb/tb_md5_mem_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/md5_mem_responder.sv
// Two-lane word-addressed RAM window terminating the md5 core's memory interface,
// with byte/halfword/word access per lane and a host port for preload and readback.
module md5_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h40000000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        Mout_oe_ram,
  input  logic [1:0]        Mout_we_ram,
  input  logic [63:0]       Mout_addr_ram,
  input  logic [63:0]       Mout_Wdata_ram,
  input  logic [11:0]       Mout_data_ram_size,
  output logic [63:0]       M_Rdata_ram,
  output logic [1:0]        M_DataRdy,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [31:0]       host_wdata,
  output logic [31:0]       host_rdata,
  output logic              access_error
);

  localparam logic [31:0] WINDOW_BYTES = 32'(4 * DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]       lane_addr  [2];
  logic [5:0]        lane_size  [2];
  logic [1:0]        lane_off   [2];
  logic [ADDR_W-1:0] lane_idx   [2];
  logic [3:0]        lane_be    [2];
  logic [31:0]       lane_wdata [2];
  logic [31:0]       lane_rd    [2];
  logic              lane_req   [2];
  logic              lane_rd_ok [2];
  logic              lane_bad   [2];

  // Per-lane decode: range, size legality, alignment, byte enables and read extraction.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      logic [3:0]  mask;
      logic [31:0] rmask;
      logic        legal;
      logic        ok;
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      mask  = 4'b0000;
      rmask = 32'h0;
      legal = 1'b0;

      lane_addr[i]  = Mout_addr_ram[32*i +: 32];
      lane_size[i]  = Mout_data_ram_size[6*i +: 6];
      lane_off[i]   = lane_addr[i][1:0];
      lane_idx[i]   = lane_addr[i][ADDR_W+1:2];

      case (lane_size[i])
        6'd8:  begin legal = 1'b1;                mask = 4'b0001; rmask = 32'h0000_00ff; end
        6'd16: begin legal = ~lane_off[i][0];     mask = 4'b0011; rmask = 32'h0000_ffff; end
        6'd32: begin legal = (lane_off[i] == 2'd0); mask = 4'b1111; rmask = 32'hffff_ffff; end
        default: ;
      endcase

      lane_req[i] = Mout_oe_ram[i] | Mout_we_ram[i];
      ok = lane_req[i] && !(Mout_oe_ram[i] && Mout_we_ram[i]) && legal &&
           ((lane_addr[i] - BASE_ADDR) < WINDOW_BYTES);

      lane_bad[i]   = lane_req[i] && !ok;
      lane_rd_ok[i] = ok && Mout_oe_ram[i];
      lane_be[i]    = (ok && Mout_we_ram[i]) ? 4'(mask << lane_off[i]) : 4'b0000;
      lane_wdata[i] = Mout_Wdata_ram[32*i +: 32] << {lane_off[i], 3'b000};
      lane_rd[i]    = (mem[lane_idx[i]] >> {lane_off[i], 3'b000}) & rmask;
    end
  end

  // Later assignments win per byte: host first, then lane 0, then lane 1.
  // NOTE: the RAM array is deliberately left out of reset so contents survive it
  // and the array can map onto block RAM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (host_we) begin
        mem[host_addr] <= host_wdata;
      end
      for (int i = 0; i < 2; i++) begin
        for (int b = 0; b < 4; b++) begin
          if (lane_be[i][b]) begin
            mem[lane_idx[i]][8*b +: 8] <= lane_wdata[i][8*b +: 8];
          end
        end
      end
    end
  end

  // NOTE: non-blocking assignments here make every read see the pre-edge RAM contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      M_Rdata_ram  <= '0;
      M_DataRdy    <= '0;
      host_rdata   <= '0;
      access_error <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        M_DataRdy[i]           <= lane_req[i];
        M_Rdata_ram[32*i +: 32] <= lane_rd_ok[i] ? lane_rd[i] : 32'h0;
      end
      host_rdata <= mem[host_addr];
      if (lane_bad[0] || lane_bad[1]) begin
        access_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_md5_mem_responder.sv
// Bench for md5_mem_responder: a byte-level memory model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_md5_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  oe, we;
  logic [63:0] addr, wdata;
  logic [11:0] size;
  logic [63:0] rdata;
  logic [1:0]  rdy;
  logic        host_we;
  logic [7:0]  host_addr;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;
  logic        err;

  int checks   = 0;
  int failures = 0;

  md5_mem_responder dut (
    .clk               (clk),
    .reset             (reset),
    .Mout_oe_ram       (oe),
    .Mout_we_ram       (we),
    .Mout_addr_ram     (addr),
    .Mout_Wdata_ram    (wdata),
    .Mout_data_ram_size(size),
    .M_Rdata_ram       (rdata),
    .M_DataRdy         (rdy),
    .host_we           (host_we),
    .host_addr         (host_addr),
    .host_wdata        (host_wdata),
    .host_rdata        (host_rdata),
    .access_error      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    return (32'(i) * 32'h01010101) ^ 32'hA5A50000;
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] mm    [256];
  bit          known [256];
  logic [63:0] exp_rdata;
  logic [1:0]  exp_rdy;
  logic [31:0] exp_host;
  bit          exp_host_known;
  bit          exp_err;
  bit          model_live = 0;

  always @(posedge clk) begin
    if (reset) begin
      exp_rdata = '0; exp_rdy = '0; exp_host = '0; exp_host_known = 1; exp_err = 0;
      model_live = 1;
    end else begin
      logic [31:0] rel [2];
      int          nb  [2];
      bit          ok  [2];
      exp_host       = mm[host_addr];
      exp_host_known = known[host_addr];
      for (int l = 0; l < 2; l++) begin
        logic [31:0] rd;
        logic [31:0] ba;
        int sz;
        sz     = int'(size[6*l +: 6]);
        rel[l] = addr[32*l +: 32] - 32'h40000000;
        nb[l]  = sz / 8;
        ok[l]  = (oe[l] ^ we[l]) && (sz == 8 || sz == 16 || sz == 32) &&
                 (rel[l] < 32'd1024) && ((int'(rel[l][1:0]) % nb[l]) == 0);
        exp_rdy[l] = oe[l] | we[l];
        if ((oe[l] | we[l]) && !ok[l]) exp_err = 1;
        rd = 32'h0;
        if (ok[l] && oe[l]) begin
          for (int k = 0; k < nb[l]; k++) begin
            ba = rel[l] + 32'(k);
            rd = rd | (32'(mm[ba[9:2]][8*ba[1:0] +: 8]) << (8*k));
          end
        end
        exp_rdata[32*l +: 32] = rd;
      end
      if (host_we) begin
        mm[host_addr]    = host_wdata;
        known[host_addr] = 1;
      end
      for (int l = 0; l < 2; l++) begin
        logic [31:0] ba;
        if (ok[l] && we[l]) begin
          for (int k = 0; k < nb[l]; k++) begin
            ba = rel[l] + 32'(k);
            mm[ba[9:2]][8*ba[1:0] +: 8] = wdata[32*l + 8*k +: 8];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("model_rdy",   64'(rdy),   64'(exp_rdy));
      chk("model_rdata", rdata,      exp_rdata);
      chk("model_err",   64'(err),   64'(exp_err));
      if (exp_host_known) chk("model_host", 64'(host_rdata), 64'(exp_host));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    oe = '0; we = '0; addr = '0; wdata = '0; size = '0;
    host_we = 1'b0; host_wdata = '0;
  endtask

  task automatic lane(input int l, input bit r, input bit w, input logic [31:0] a,
                      input logic [5:0] s, input logic [31:0] d);
    oe[l] = r; we[l] = w;
    addr[32*l +: 32] = a; wdata[32*l +: 32] = d; size[6*l +: 6] = s;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) known[i] = 0;
    reset = 1'b1; host_addr = '0; idle();
    repeat (2) step();
    reset = 1'b0;

    for (int i = 0; i < 256; i++) begin
      host_we = 1'b1; host_addr = 8'(i); host_wdata = pat(i);
      step();
    end
    idle(); host_addr = '0;

    // Host preload then lane 0 word read
    host_we = 1'b1; host_addr = 8'd0; host_wdata = 32'h00000080;
    step(); idle();
    lane(0, 1, 0, 32'h40000000, 6'd32, 32'h0);
    step(); idle();
    @(negedge clk);
    chk("t1_rdy",   64'(rdy), 64'h1);
    chk("t1_lane0", 64'(rdata[31:0]), 64'h00000080);
    chk("t1_lane1", 64'(rdata[63:32]), 64'h0);

    // Lane 1 word write then byte overwrite
    lane(1, 0, 1, 32'h40000104, 6'd32, 32'hd98c1dd4);
    step(); idle();
    lane(1, 0, 1, 32'h40000106, 6'd8, 32'h000000AB);
    step(); idle(); host_addr = 8'd65;
    step();
    @(negedge clk);
    chk("t2_host65", 64'(host_rdata), 64'hd9ab1dd4);
    lane(0, 1, 0, 32'h40000106, 6'd16, 32'h0);
    step(); idle();
    @(negedge clk);
    chk("t2_half", 64'(rdata[31:0]), 64'h0000d9ab);

    // Same-word collision between lanes
    lane(0, 0, 1, 32'h40000200, 6'd32, 32'h11111111);
    lane(1, 0, 1, 32'h40000200, 6'd32, 32'h22222222);
    step(); idle(); host_addr = 8'd128;
    @(negedge clk);
    chk("t3_rdy", 64'(rdy), 64'h3);
    chk("t3_err_clear", 64'(err), 64'h0);
    step();
    @(negedge clk);
    chk("t3_word", 64'(host_rdata), 64'h22222222);

    // Invalid requests on lane 0
    lane(0, 1, 0, 32'h40000400, 6'd32, 32'h0);
    step(); idle();
    @(negedge clk);
    chk("t4_oor_rdy",  64'(rdy), 64'h1);
    chk("t4_oor_data", rdata, 64'h0);
    chk("t4_oor_err",  64'(err), 64'h1);
    lane(0, 0, 1, 32'h40000002, 6'd32, 32'hFFFFFFFF);
    step(); idle(); host_addr = 8'd0;
    @(negedge clk);
    chk("t4_mis_rdy", 64'(rdy), 64'h1);
    chk("t4_mis_err", 64'(err), 64'h1);
    step();
    @(negedge clk);
    chk("t4_mis_ram", 64'(host_rdata), 64'h00000080);
    lane(0, 1, 0, 32'h40000000, 6'd24, 32'h0);
    step(); idle();
    @(negedge clk);
    chk("t4_size_rdy",  64'(rdy), 64'h1);
    chk("t4_size_data", rdata, 64'h0);
    chk("t4_size_err",  64'(err), 64'h1);

    // Back-to-back word reads 0..7
    lane(0, 1, 0, 32'h40000000, 6'd32, 32'h0);
    for (int i = 0; i < 8; i++) begin
      step();
      @(negedge clk);
      chk("t5_rdy",  64'(rdy), 64'h1);
      chk("t5_data", 64'(rdata[31:0]), (i == 0) ? 64'h80 : 64'(pat(i)));
      if (i < 7) lane(0, 1, 0, 32'h40000000 + 32'(4*(i+1)), 6'd32, 32'h0);
      else idle();
    end
    step();
    @(negedge clk);
    chk("t5_idle_rdy", 64'(rdy), 64'h0);

    // Write coincident with reset is dropped
    lane(0, 0, 1, 32'h4000000C, 6'd32, 32'hDEADBEEF);
    reset = 1'b1;
    step(); reset = 1'b0; idle(); host_addr = 8'd3;
    @(negedge clk);
    chk("t6_rdy",   64'(rdy), 64'h0);
    chk("t6_rdata", rdata, 64'h0);
    chk("t6_host",  64'(host_rdata), 64'h0);
    chk("t6_err",   64'(err), 64'h0);
    step(); host_addr = 8'd65;
    @(negedge clk);
    chk("t6_word3", 64'(host_rdata), 64'(pat(3)));
    step();
    @(negedge clk);
    chk("t6_word65", 64'(host_rdata), 64'hd9ab1dd4);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
